// File: rtl/frame_parity_checker.sv
// Framed serial deserialiser with running Mealy parity and even/odd frame check.
// Define PARITY_ERR_CNT_EN to add the saturating err_count output.
module frame_parity_checker #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 odd_mode,
    input  logic                 valid,
    input  logic                 x,
    output logic                 parity,
    output logic                 busy,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_done,
    output logic                 parity_err
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]     err_count
`endif
);

    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_acc;
    logic                 r_mode_q;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_frame_done;
    logic                 r_parity_err;

    logic w_load;
    logic w_take_bit;
    logic w_take_par;
    logic w_parity;
    logic w_expected;
    logic w_bad;

    assign w_expected = r_par_acc ^ r_mode_q;
    assign w_bad      = x ^ w_expected;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_take_bit  = 1'b0;
        w_take_par  = 1'b0;
        w_parity    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // valid alongside start is deliberately dropped
                if (start) begin
                    w_state_nxt = S_DATA;
                    w_load      = 1'b1;
                end
            end
            S_DATA: begin
                w_parity = r_par_acc ^ (valid & x);
                if (valid) begin
                    w_take_bit = 1'b1;
                    if (r_bit_cnt == LAST) begin
                        w_state_nxt = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                w_parity = w_expected;
                if (valid) begin
                    w_take_par  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_acc    <= 1'b0;
            r_mode_q     <= 1'b0;
            r_data_out   <= '0;
            r_frame_done <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_parity_err <= 1'b0;
            if (w_load) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_par_acc <= 1'b0;
                r_mode_q  <= odd_mode;
            end
            if (w_take_bit) begin
                r_shift[r_bit_cnt] <= x;
                r_par_acc          <= r_par_acc ^ x;
                r_bit_cnt          <= r_bit_cnt + CW'(1);
            end
            if (w_take_par) begin
                r_data_out   <= r_shift;
                r_frame_done <= 1'b1;
                r_parity_err <= w_bad;
            end
        end
    end

`ifdef PARITY_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_err_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_take_par && w_bad && (r_err_count != CNT_MAX)) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`endif

    assign parity     = w_parity;
    assign busy       = (r_state != S_IDLE);
    assign data_out   = r_data_out;
    assign frame_done = r_frame_done;
    assign parity_err = r_parity_err;

endmodule

// File: tb/tb_frame_parity_checker.sv
// Randomised bench for frame_parity_checker against a word-level frame model.
// Checks err_count too when built with PARITY_ERR_CNT_EN.
module tb_frame_parity_checker;

    localparam int DB = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          odd_mode;
    logic          valid;
    logic          x;
    logic          parity;
    logic          busy;
    logic [DB-1:0] data_out;
    logic          frame_done;
    logic          parity_err;
`ifdef PARITY_ERR_CNT_EN
    logic [CW-1:0] err_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [DB-1:0] last_word = '0;
    int            err_model = 0;

    frame_parity_checker #(
        .DATA_BITS(DB),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .odd_mode  (odd_mode),
        .valid     (valid),
        .x         (x),
        .parity    (parity),
        .busy      (busy),
        .data_out  (data_out),
        .frame_done(frame_done),
        .parity_err(parity_err)
`ifdef PARITY_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        start    = 1'($urandom);
        odd_mode = 1'($urandom);
        x        = 1'($urandom);
    endtask

    task automatic chk_cnt();
`ifdef PARITY_ERR_CNT_EN
        chk("err_count", 32'(err_count), 32'(err_model));
`endif
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0;
            valid = 1'($urandom);
            x     = 1'($urandom);
            #1 chk("idle_parity", 32'(parity), 0);
            step();
            chk("idle_busy", 32'(busy), 0);
            chk("idle_done", 32'(frame_done), 0);
            chk("idle_data", 32'(data_out), 32'(last_word));
        end
    endtask

    task automatic run_frame(input logic [DB-1:0] w, input logic m,
                             input logic pb, input int maxst);
        logic acc;
        logic exp_err;
        int   n;
        @(negedge clk);
        start    = 1'b1;
        odd_mode = m;
        valid    = 1'($urandom);
        x        = 1'($urandom);
        #1 chk("start_parity", 32'(parity), 0);
        step();
        chk("start_busy", 32'(busy), 1);
        chk("start_done", 32'(frame_done), 0);
        chk("hold_data", 32'(data_out), 32'(last_word));
        acc = 1'b0;
        for (int i = 0; i < DB; i++) begin
            n = $urandom_range(0, maxst);
            repeat (n) begin
                @(negedge clk);
                noise();
                valid = 1'b0;
                #1 chk("stall_parity", 32'(parity), 32'(acc));
                step();
                chk("stall_busy", 32'(busy), 1);
            end
            @(negedge clk);
            noise();
            valid = 1'b1;
            x     = w[i];
            #1 chk("data_parity", 32'(parity), 32'(acc ^ w[i]));
            step();
            acc = acc ^ w[i];
            chk("data_busy", 32'(busy), 1);
            chk("data_done", 32'(frame_done), 0);
        end
        n = $urandom_range(0, maxst);
        repeat (n) begin
            @(negedge clk);
            noise();
            valid = 1'b0;
            #1 chk("chk_stall_parity", 32'(parity), 32'(acc ^ m));
            step();
            chk("chk_stall_busy", 32'(busy), 1);
        end
        @(negedge clk);
        noise();
        valid = 1'b1;
        x     = pb;
        #1 chk("check_parity", 32'(parity), 32'(acc ^ m));
        step();
        exp_err = (pb != (^w ^ m));
        last_word = w;
        if (exp_err && err_model < (1 << CW) - 1) err_model++;
        chk("done", 32'(frame_done), 1);
        chk("parity_err", 32'(parity_err), 32'(exp_err));
        chk("data_out", 32'(data_out), 32'(w));
        chk("end_busy", 32'(busy), 0);
        chk_cnt();
        @(negedge clk);
        start = 1'b0;
        valid = 1'b0;
    endtask

    task automatic abort_frame();
        @(negedge clk);
        start    = 1'b1;
        odd_mode = 1'b0;
        valid    = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            valid = 1'b1;
            x     = 1'($urandom);
            step();
        end
        @(negedge clk);
        valid = 1'b0;
        reset = 1'b1;
        #1;
        last_word = '0;
        err_model = 0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_data", 32'(data_out), 0);
        chk_cnt();
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_done", 32'(frame_done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DB-1:0] w;
        reset    = 1'b1;
        start    = 1'b0;
        odd_mode = 1'b0;
        valid    = 1'b0;
        x        = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_parity", 32'(parity), 0);
        chk("reset_data", 32'(data_out), 0);
        chk("reset_done", 32'(frame_done), 0);
        chk("reset_err", 32'(parity_err), 0);
        chk_cnt();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_cycles(2);

        run_frame(8'h0D, 1'b0, 1'b1, 0);
        run_frame(8'h0D, 1'b0, 1'b0, 0);
        run_frame(8'h0D, 1'b1, 1'b0, 2);
        run_frame(8'hA5, 1'b0, 1'b0, 0);
        idle_cycles(1);

        // stall 5 cycles before every bit
        @(negedge clk);
        run_frame_stall5();

        abort_frame();
        run_frame(8'h0D, 1'b0, 1'b1, 1);

        repeat (5) run_frame(8'h0D, 1'b0, 1'b0, 0);

        for (int f = 0; f < 40; f++) begin
            w = DB'($urandom);
            run_frame(w, 1'($urandom), 1'($urandom), 2);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic run_frame_stall5();
        logic [DB-1:0] w;
        w = 8'hA5;
        start    = 1'b1;
        odd_mode = 1'b0;
        valid    = 1'b0;
        step();
        chk("s5_busy0", 32'(busy), 1);
        for (int i = 0; i < DB; i++) begin
            repeat (5) begin
                @(negedge clk);
                start = 1'($urandom);
                valid = 1'b0;
                step();
                chk("s5_busy", 32'(busy), 1);
            end
            @(negedge clk);
            start = 1'b1;
            valid = 1'b1;
            x     = w[i];
            step();
        end
        @(negedge clk);
        start = 1'b0;
        valid = 1'b1;
        x     = 1'b0;
        step();
        last_word = w;
        chk("s5_done", 32'(frame_done), 1);
        chk("s5_err", 32'(parity_err), 0);
        chk("s5_data", 32'(data_out), 32'(w));
        chk_cnt();
        @(negedge clk);
        valid = 1'b0;
    endtask

endmodule
